// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - shared segment constants, digit table, FSM encoding and BCD helper
package rpn_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  // Active-low gfedcba patterns, entry 9 first so DIGIT_SEG[d] selects digit d.
  localparam logic [9:0][6:0] DIGIT_SEG = {
    7'b0010000,
    7'b0000000,
    7'b1111000,
    7'b0000010,
    7'b0010010,
    7'b0011001,
    7'b0110000,
    7'b0100100,
    7'b1111001,
    7'b1000000
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Double-dabble correction step: any nibble of 5 or more gets +3 before the shift.
  function automatic logic [19:0] add3_bcd(input logic [19:0] bcd);
    logic [19:0] r;
    r = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_digit.sv
// rtl/seg7_digit.sv - one BCD digit to active-low 7-segment pattern with blanking
module seg7_digit
  import rpn_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (bcd <= 4'd9)) begin
      seg = DIGIT_SEG[bcd];
    end
  end

endmodule

// File: rtl/rpn_result_display.sv
// rtl/rpn_result_display.sv - iterative binary-to-decimal display driver for HEX5..HEX0
module rpn_result_display
  import rpn_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             err,
  output logic             busy,
  output logic             done,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t          state;
  logic            neg_q;
  logic            err_q;
  logic [WIDTH:0]  mag_q;
  logic [19:0]     bcd_q;
  logic [CW-1:0]   cnt;

  logic            neg_in;
  logic [WIDTH:0]  mag_in;
  logic [3:0]      dig   [5];
  logic            blank [5];
  logic [6:0]      seg   [5];

  // One extra magnitude bit keeps the most-negative input exact.
  always_comb begin
    neg_in = SIGNED && value[WIDTH-1];
    mag_in = neg_in ? (~{1'b1, value} + (WIDTH+1)'(1)) : {1'b0, value};
  end

  // Leading-zero blanking ripples down from HEX4; the ones digit always shows.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      dig[i] = bcd_q[4*i +: 4];
    end
    blank[4] = (dig[4] == 4'd0);
    for (int i = 3; i >= 1; i--) begin
      blank[i] = blank[i+1] && (dig[i] == 4'd0);
    end
    blank[0] = 1'b0;
  end

  for (genvar g = 0; g < 5; g++) begin : g_digit
    seg7_digit u_digit (
      .bcd   (dig[g]),
      .blank (blank[g]),
      .seg   (seg[g])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      neg_q <= 1'b0;
      err_q <= 1'b0;
      mag_q <= '0;
      bcd_q <= '0;
      cnt   <= '0;
      HEX0  <= SEG_BLANK;
      HEX1  <= SEG_BLANK;
      HEX2  <= SEG_BLANK;
      HEX3  <= SEG_BLANK;
      HEX4  <= SEG_BLANK;
      HEX5  <= SEG_BLANK;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            neg_q <= neg_in;
            err_q <= err;
            mag_q <= mag_in;
            bcd_q <= '0;
            cnt   <= CW'(WIDTH - 1);
            busy  <= 1'b1;
            state <= err ? LATCH : CONV;
          end
        end
        CONV: begin
          // Truncating cast drops the BCD carry-out, which cannot be set for WIDTH <= 16.
          bcd_q <= 20'({add3_bcd(bcd_q), mag_q[WIDTH-1]});
          mag_q <= mag_q << 1;
          cnt   <= cnt - CW'(1);
          if (cnt == '0) begin
            state <= LATCH;
          end
        end
        LATCH: begin
          if (err_q) begin
            HEX5 <= SEG_BLANK;
            HEX4 <= SEG_BLANK;
            HEX3 <= SEG_BLANK;
            HEX2 <= SEG_E;
            HEX1 <= SEG_R;
            HEX0 <= SEG_R;
          end else begin
            HEX5 <= neg_q ? SEG_MINUS : SEG_BLANK;
            HEX4 <= seg[4];
            HEX3 <= seg[3];
            HEX2 <= seg[2];
            HEX1 <= seg[1];
            HEX0 <= seg[0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
